// File: rtl/hpu_csr_pkg.sv
// Shared definitions for the HPU control/status register block:
// register offsets, CTRL bit positions, AXI response codes and bus FSM states.
package hpu_csr_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_ADDR_I   = 8'h08;
  localparam logic [7:0] OFF_ADDR_J   = 8'h0C;
  localparam logic [7:0] OFF_CONTROL  = 8'h10;
  localparam logic [7:0] OFF_ITEM_NUM = 8'h14;
  localparam logic [7:0] OFF_INFO     = 8'h18;

  localparam int CTRL_MATW   = 0;
  localparam int CTRL_RUN    = 1;
  localparam int CTRL_LAST   = 2;
  localparam int CTRL_IRQ_EN = 8;
  localparam int CTRL_W      = 9;
  localparam logic [CTRL_W-1:0] CTRL_MASK = 9'h107;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_AWW,
    ST_AR1,
    ST_AR2
  } axi_state_e;

endpackage

// File: rtl/hpu_csr_if.sv
// AXI4-Lite slave bundle (32-bit data) between the PS master and hpu_csr.
// The master modport is the PS side, the slave modport is the register block.
interface hpu_csr_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/csr_strb_reg.sv
// W-bit register with per-byte-lane strobed write and a per-bit hardware clear.
// A strobed write to a lane takes priority over the hardware clear of its bits.
module csr_strb_reg #(
  parameter int            W   = 32,
  parameter logic [W-1:0]  RST = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [(W+7)/8-1:0] strb,
  input  logic [W-1:0]       d,
  input  logic [W-1:0]       clr,
  output logic [W-1:0]       q
);

  logic [W-1:0] lane_mask;
  logic [W-1:0] wr_mask;

  for (genvar i = 0; i < W; i++) begin : g_lane
    assign lane_mask[i] = strb[i/8];
  end

  assign wr_mask = we ? lane_mask : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST;
    end else begin
      q <= (d & wr_mask) | (q & ~wr_mask & ~clr);
    end
  end

endmodule

// File: rtl/hpu_csr.sv
// AXI4-Lite CSR block for the HPU: run/matw/last control, loop bounds, item count,
// sticky done with interrupt. Write commits one edge after AW+W; read data registered, RVALID two cycles after AR.
module hpu_csr
  import hpu_csr_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int IJ_W      = 20,
  parameter int ITEM_W    = 16,
  parameter int NUM_CORES = 1
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  hpu_csr_if.slave          s_axi,
  input  logic [ITEM_W-1:0] mat_a,
  input  logic              s_fin,
  output logic              run,
  output logic              matw,
  output logic              last,
  output logic [IJ_W-1:0]   addr_i,
  output logic [IJ_W-1:0]   addr_j,
  output logic [ITEM_W-1:0] item_num,
  output logic [31:0]       control,
  output logic              irq
);

  localparam int AW = ADDR_W - 2;
  localparam logic [AW-1:0] W_CTRL     = AW'(OFF_CTRL[7:2]);
  localparam logic [AW-1:0] W_STATUS   = AW'(OFF_STATUS[7:2]);
  localparam logic [AW-1:0] W_ADDR_I   = AW'(OFF_ADDR_I[7:2]);
  localparam logic [AW-1:0] W_ADDR_J   = AW'(OFF_ADDR_J[7:2]);
  localparam logic [AW-1:0] W_CONTROL  = AW'(OFF_CONTROL[7:2]);
  localparam logic [AW-1:0] W_ITEM_NUM = AW'(OFF_ITEM_NUM[7:2]);
  localparam logic [AW-1:0] W_INFO     = AW'(OFF_INFO[7:2]);

  axi_state_e        state_q, state_d;
  logic              rst_done_q;
  logic              awready, wready, arready;
  logic              aw_hs, w_hs, ar_hs;
  logic              commit_q;
  logic [AW-1:0]     waddr_q, raddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       rdata_q, rd_data;
  logic [1:0]        rresp_q;
  logic              rd_hit, wr_hit;
  logic [CTRL_W-1:0] ctrl_q;
  logic              done_q;
  logic              matw_clr;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Write arbitration wins over reads, so AR is only acknowledged when no write is pending.
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        awready = rst_done_q;
        wready  = rst_done_q;
        arready = rst_done_q && !s_axi.awvalid && !s_axi.wvalid;
        if (rst_done_q) begin
          if (s_axi.awvalid && s_axi.wvalid) state_d = ST_AWW;
          else if (s_axi.awvalid)            state_d = ST_AW;
          else if (s_axi.wvalid)             state_d = ST_W;
          else if (s_axi.arvalid)            state_d = ST_AR1;
        end
      end
      ST_AW: begin
        wready = 1'b1;
        if (s_axi.wvalid) state_d = ST_AWW;
      end
      ST_W: begin
        awready = 1'b1;
        if (s_axi.awvalid) state_d = ST_AWW;
      end
      ST_AWW:  if (s_axi.bready) state_d = ST_IDLE;
      ST_AR1:  state_d = ST_AR2;
      ST_AR2:  if (s_axi.rready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
    end
  end

  assign aw_hs = s_axi.awvalid && awready;
  assign w_hs  = s_axi.wvalid && wready;
  assign ar_hs = s_axi.arvalid && arready;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      commit_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      commit_q <= (state_d == ST_AWW) && (state_q != ST_AWW);
      if (aw_hs) waddr_q <= s_axi.awaddr[ADDR_W-1:2];
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (ar_hs) raddr_q <= s_axi.araddr[ADDR_W-1:2];
      if (state_q == ST_AR1) begin
        rdata_q <= rd_data;
        rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Mapped offsets are contiguous from CTRL up to INFO.
  assign wr_hit = (waddr_q <= W_INFO);

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.arready = arready;
  assign s_axi.bvalid  = (state_q == ST_AWW);
  assign s_axi.bresp   = wr_hit ? RESP_OKAY : RESP_SLVERR;
  assign s_axi.rvalid  = (state_q == ST_AR2);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign matw_clr = ctrl_q[CTRL_MATW] && (mat_a == item_num);

  csr_strb_reg #(.W(CTRL_W)) u_ctrl (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .we(commit_q && waddr_q == W_CTRL), .strb(wstrb_q[1:0]),
    .d(wdata_q[CTRL_W-1:0] & CTRL_MASK), .clr({{(CTRL_W-1){1'b0}}, matw_clr}),
    .q(ctrl_q)
  );

  csr_strb_reg #(.W(IJ_W)) u_addr_i (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .we(commit_q && waddr_q == W_ADDR_I), .strb(wstrb_q[(IJ_W+7)/8-1:0]),
    .d(wdata_q[IJ_W-1:0]), .clr('0), .q(addr_i)
  );

  csr_strb_reg #(.W(IJ_W)) u_addr_j (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .we(commit_q && waddr_q == W_ADDR_J), .strb(wstrb_q[(IJ_W+7)/8-1:0]),
    .d(wdata_q[IJ_W-1:0]), .clr('0), .q(addr_j)
  );

  csr_strb_reg #(.W(32)) u_control (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .we(commit_q && waddr_q == W_CONTROL), .strb(wstrb_q),
    .d(wdata_q), .clr('0), .q(control)
  );

  csr_strb_reg #(.W(ITEM_W)) u_item_num (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .we(commit_q && waddr_q == W_ITEM_NUM), .strb(wstrb_q[(ITEM_W+7)/8-1:0]),
    .d(wdata_q[ITEM_W-1:0]), .clr('0), .q(item_num)
  );

  // A finishing run sets done even if software is clearing it in the same cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      done_q <= 1'b0;
    end else if (s_fin) begin
      done_q <= 1'b1;
    end else if (commit_q && waddr_q == W_STATUS && wstrb_q[0] && wdata_q[0]) begin
      done_q <= 1'b0;
    end
  end

  assign run  = ctrl_q[CTRL_RUN];
  assign matw = ctrl_q[CTRL_MATW];
  assign last = ctrl_q[CTRL_LAST];
  assign irq  = done_q && ctrl_q[CTRL_IRQ_EN];

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    case (raddr_q)
      W_CTRL:     rd_data = {{(32-CTRL_W){1'b0}}, ctrl_q};
      W_STATUS:   rd_data = {30'b0, run && !done_q, done_q};
      W_ADDR_I:   rd_data = 32'(addr_i);
      W_ADDR_J:   rd_data = 32'(addr_j);
      W_CONTROL:  rd_data = control;
      W_ITEM_NUM: rd_data = 32'(item_num);
      W_INFO:     rd_data = {16'(NUM_CORES), 8'(ITEM_W), 8'(IJ_W)};
      default:    rd_hit  = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_hpu_csr.sv
// Directed bench for hpu_csr: register map, strobes, matw auto-clear, done/irq,
// SLVERR decode, read stall stability and reset in the middle of a write.
module tb_hpu_csr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mat_a = '0;
  logic        s_fin = 1'b0;
  logic        run, matw, last, irq;
  logic [19:0] addr_i, addr_j;
  logic [15:0] item_num;
  logic [31:0] control;
  int          checks = 0;
  int          errors = 0;

  hpu_csr_if #(.ADDR_W(12)) axi ();

  hpu_csr #(.ADDR_W(12), .IJ_W(20), .ITEM_W(16), .NUM_CORES(1)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(axi),
    .mat_a(mat_a), .s_fin(s_fin), .run(run), .matw(matw), .last(last),
    .addr_i(addr_i), .addr_j(addr_j), .item_num(item_num), .control(control), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int  n;
    logic aw_go, w_go;
    axi.awaddr = a; axi.awvalid = 1'b1;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
    n = 0;
    while (axi.awvalid || axi.wvalid) begin
      aw_go = axi.awvalid && axi.awready;
      w_go  = axi.wvalid && axi.wready;
      tick();
      if (aw_go) axi.awvalid = 1'b0;
      if (w_go) axi.wvalid = 1'b0;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL write_hs_timeout addr=%h", a);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      end
    end
    axi.bready = 1'b1;
    n = 0;
    while (!axi.bvalid && n < 50) begin tick(); n++; end
    if (!axi.bvalid) begin
      checks++; errors++;
      $display("FAIL write_b_timeout addr=%h", a);
    end
    resp = axi.bresp;
    tick();
    axi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    axi.araddr = a; axi.arvalid = 1'b1;
    n = 0;
    while (!axi.arready && n < 50) begin tick(); n++; end
    if (!axi.arready) begin
      checks++; errors++;
      $display("FAIL read_ar_timeout addr=%h", a);
    end
    tick();
    axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    n = 0;
    while (!axi.rvalid && n < 50) begin tick(); n++; end
    if (!axi.rvalid) begin
      checks++; errors++;
      $display("FAIL read_r_timeout addr=%h", a);
    end
    d = axi.rdata;
    resp = axi.rresp;
    tick();
    axi.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, exp_d;
    logic [1:0]  r;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake got=%b exp=00000",
               {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid});
    end
    checks++;
    if ({run, matw, last, irq} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl_bits got=%b exp=0000", {run, matw, last, irq});
    end
    checks++;
    if (addr_i !== '0 || addr_j !== '0 || item_num !== '0 || control !== '0) begin
      errors++;
      $display("FAIL reset_regs addr_i=%h addr_j=%h item_num=%h control=%h exp=0",
               addr_i, addr_j, item_num, control);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    for (int i = 0; i < 7; i++) begin
      axi_read(12'(i * 4), d, r);
      exp_d = (i == 6) ? 32'h0001_1014 : 32'h0;
      checks++;
      if (d !== exp_d) begin
        errors++;
        $display("FAIL reset_read off=%0h got=%h exp=%h", i * 4, d, exp_d);
      end
      checks++;
      if (r !== 2'b00) begin
        errors++;
        $display("FAIL reset_rresp off=%0h got=%b exp=00", i * 4, r);
      end
    end
  endtask

  task automatic test_strb_write();
    logic [31:0] d;
    logic [1:0]  r;
    axi.awaddr = 12'h008; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    checks++;
    if (axi.awready !== 1'b0 || axi.wready !== 1'b1) begin
      errors++;
      $display("FAIL aw_state_ready awready=%b wready=%b exp=0,1", axi.awready, axi.wready);
    end
    tick();
    axi.wdata = 32'h0001_2345; axi.wstrb = 4'b0001; axi.wvalid = 1'b1;
    tick();
    axi.wvalid = 1'b0;
    checks++;
    if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin
      errors++;
      $display("FAIL bvalid_after_w bvalid=%b bresp=%b exp=1,00", axi.bvalid, axi.bresp);
    end
    checks++;
    if (addr_i !== 20'h0) begin
      errors++;
      $display("FAIL addr_i_precommit got=%h exp=00000", addr_i);
    end
    tick();
    checks++;
    if (addr_i !== 20'h00045 || axi.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL addr_i_commit got=%h bvalid=%b exp=00045,1", addr_i, axi.bvalid);
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    checks++;
    if (axi.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL bvalid_release got=%b exp=0", axi.bvalid);
    end
    axi_write(12'h008, 32'hFFFF_FFFF, 4'b0000, r);
    checks++;
    if (r !== 2'b00 || addr_i !== 20'h00045) begin
      errors++;
      $display("FAIL zero_strb bresp=%b addr_i=%h exp=00,00045", r, addr_i);
    end
    axi_write(12'h010, 32'hAABB_CCDD, 4'b1111, r);
    axi_write(12'h010, 32'h1122_3344, 4'b0110, r);
    checks++;
    if (control !== 32'hAA22_33DD) begin
      errors++;
      $display("FAIL control_strb got=%h exp=aa2233dd", control);
    end
    axi_read(12'h008, d, r);
    checks++;
    if (d !== 32'h0000_0045) begin
      errors++;
      $display("FAIL addr_i_readback got=%h exp=00000045", d);
    end
  endtask

  task automatic test_matw();
    logic [31:0] d;
    logic [1:0]  r;
    mat_a = '0;
    axi_write(12'h014, 32'd99, 4'hF, r);
    axi_write(12'h000, 32'h1, 4'hF, r);
    checks++;
    if (matw !== 1'b1 || item_num !== 16'd99) begin
      errors++;
      $display("FAIL matw_set matw=%b item_num=%0d exp=1,99", matw, item_num);
    end
    for (int v = 0; v <= 99; v++) begin
      mat_a = 16'(v);
      if (v == 99) begin
        checks++;
        if (matw !== 1'b1) begin
          errors++;
          $display("FAIL matw_before_match got=%b exp=1", matw);
        end
      end
      tick();
    end
    checks++;
    if (matw !== 1'b0) begin
      errors++;
      $display("FAIL matw_autoclear got=%b exp=0", matw);
    end
    mat_a = '0;
    axi_read(12'h000, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL ctrl_after_clear got=%h exp=00000000", d);
    end
  endtask

  task automatic test_done_irq();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(12'h000, 32'h0000_0102, 4'hF, r);
    checks++;
    if (run !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL run_set run=%b irq=%b exp=1,0", run, irq);
    end
    axi_read(12'h004, d, r);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL status_busy got=%h exp=00000002", d);
    end
    s_fin = 1'b1; tick(); s_fin = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_on_fin got=%b exp=1", irq);
    end
    axi_read(12'h004, d, r);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL status_done got=%h exp=00000001", d);
    end
    axi.awaddr = 12'h004; axi.awvalid = 1'b1;
    axi.wdata = 32'h1; axi.wstrb = 4'b0001; axi.wvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b1; s_fin = 1'b1;
    tick();
    axi.bready = 1'b0; s_fin = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_w1c irq=%b exp=1", irq);
    end
    axi_write(12'h004, 32'h1, 4'b0001, r);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_clear irq=%b exp=0", irq);
    end
    axi_read(12'h004, d, r);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL status_after_w1c got=%h exp=00000002", d);
    end
    axi_write(12'h000, 32'h0000_0100, 4'hF, r);
    s_fin = 1'b1; tick(); s_fin = 1'b0;
    checks++;
    if (irq !== 1'b1 || run !== 1'b0) begin
      errors++;
      $display("FAIL fin_while_idle irq=%b run=%b exp=1,0", irq, run);
    end
    axi_write(12'h004, 32'h1, 4'b0001, r);
  endtask

  task automatic test_slverr();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(12'h040, 32'hFFFF_FFFF, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin
      errors++;
      $display("FAIL unmapped_bresp got=%b exp=10", r);
    end
    axi_read(12'h040, d, r);
    checks++;
    if (r !== 2'b10 || d !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read rresp=%b rdata=%h exp=10,00000000", r, d);
    end
    checks++;
    if (addr_i !== 20'h00045 || addr_j !== 20'h0 || control !== 32'hAA22_33DD ||
        item_num !== 16'd99 || {run, matw, last, irq} !== 4'b0) begin
      errors++;
      $display("FAIL unmapped_no_change addr_i=%h addr_j=%h control=%h item_num=%0d ctl=%b",
               addr_i, addr_j, control, item_num, {run, matw, last, irq});
    end
  endtask

  task automatic test_read_stall();
    logic [1:0] r;
    axi.araddr = 12'h004; axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_early got=%b exp=0", axi.rvalid);
    end
    tick();
    s_fin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h0 || axi.rresp !== 2'b00) begin
        errors++;
        $display("FAIL rstall_stable cyc=%0d rvalid=%b rdata=%h rresp=%b exp=1,00000000,00",
                 i, axi.rvalid, axi.rdata, axi.rresp);
      end
      tick();
      s_fin = 1'b0;
    end
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL rstall_release rvalid=%b irq=%b exp=0,1", axi.rvalid, irq);
    end
    axi_write(12'h004, 32'h1, 4'b0001, r);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    axi.awaddr = 12'h008; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    checks++;
    if (axi.wready !== 1'b1 || axi.awready !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_aw wready=%b awready=%b exp=1,0", axi.wready, axi.awready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} !== 5'b0 ||
        {run, matw, last, irq} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs hs=%b ctl=%b exp=0",
               {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid},
               {run, matw, last, irq});
    end
    checks++;
    if (addr_i !== '0 || control !== '0 || item_num !== '0) begin
      errors++;
      $display("FAIL mid_reset_regs addr_i=%h control=%h item_num=%h exp=0",
               addr_i, control, item_num);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid} !== 4'b1110) begin
      errors++;
      $display("FAIL mid_back_idle got=%b exp=1110",
               {axi.awready, axi.wready, axi.arready, axi.bvalid});
    end
    axi_read(12'h008, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++;
      $display("FAIL mid_read_after rdata=%h rresp=%b exp=00000000,00", d, r);
    end
  endtask

  initial begin
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    test_reset();
    test_strb_write();
    test_matw();
    test_done_irq();
    test_slverr();
    test_read_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
